// File: rtl/ram_dma_2p_pkg.sv
// Shared constants and encodings for the two-port RAM DMA engine.
// Contents: RAM geometry (DATA_W, ADDR_W, DEPTH), transfer length width,
// FSM state encoding, transfer mode encoding and the length clamp helper.
package ram_dma_2p_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DEPTH  = 128;
   localparam int unsigned LEN_W  = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

   typedef enum logic {
      ModeCopy = 1'b0,
      ModeFill = 1'b1
   } mode_e;

   // Requests longer than the RAM are limited to one full pass.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      return (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
   endfunction

endpackage

// File: rtl/ram_dma_2p_if.sv
// RAM-side bus of the DMA engine, matching the 2-port 16x128 RAM pinout.
// Port 0: read_en0, write_en0, addr0, din0. Port 1: read_en1, write_en1, addr1, dout1.
// Modports: master (DMA side, drives strobes/addresses/write data),
//           slave  (RAM side, returns dout1).
interface ram_dma_2p_if;
   import ram_dma_2p_pkg::*;

   logic              read_en0;
   logic              write_en0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] din0;
   logic              read_en1;
   logic              write_en1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] dout1;

   modport master (
      output read_en0, write_en0, addr0, din0,
      output read_en1, write_en1, addr1,
      input  dout1
   );

   modport slave (
      input  read_en0, write_en0, addr0, din0,
      input  read_en1, write_en1, addr1,
      output dout1
   );

endinterface

// File: rtl/dma_addr_gen.sv
// Offset generator for the DMA engine.
// Ports: clk, rst_n; load (first word of a transfer, operands on *_in), step (next word);
//        mode_in, len_in, src_in, dst_in (transfer operands, sampled on load);
//        off (offset of the word issued this cycle), prev_off (offset issued last time),
//        last (the word issued this cycle is the final one).
// Offsets are valid combinationally in the same cycle as load so the top can register the
// first RAM access on the accepting edge.
module dma_addr_gen
   import ram_dma_2p_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  mode_e             mode_in,
   input  logic [LEN_W-1:0]  len_in,
   input  logic [ADDR_W-1:0] src_in,
   input  logic [ADDR_W-1:0] dst_in,
   output logic [ADDR_W-1:0] off,
   output logic [ADDR_W-1:0] prev_off,
   output logic              last
);

   logic [LEN_W-1:0]  cnt_q;
   logic [LEN_W-1:0]  len_q;
   logic              desc_q;
   logic [ADDR_W-1:0] prev_off_q;
   logic [ADDR_W-1:0] diff;
   logic              desc_new;
   logic [LEN_W-1:0]  k;
   logic [LEN_W-1:0]  l;
   logic              desc;

   assign diff = dst_in - src_in;
   // dst inside (src, src+len-1]: an ascending copy would overwrite unread source words.
   assign desc_new = (mode_in == ModeCopy) && (diff != '0) &&
                     (LEN_W'(diff) <= len_in - LEN_W'(1));

   assign k    = load ? '0 : cnt_q;
   assign l    = load ? len_in : len_q;
   assign desc = load ? desc_new : desc_q;

   assign off      = desc ? ADDR_W'(l - k - LEN_W'(1)) : ADDR_W'(k);
   assign last     = (k == l - LEN_W'(1));
   assign prev_off = prev_off_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         len_q      <= '0;
         desc_q     <= 1'b0;
         prev_off_q <= '0;
      end else begin
         if (load) begin
            len_q  <= len_in;
            desc_q <= desc_new;
         end
         if (load || step) begin
            cnt_q      <= k + LEN_W'(1);
            prev_off_q <= off;
         end
      end
   end

endmodule

// File: rtl/ram_dma_2p.sv
// DMA engine for a 2-port 16x128 RAM: copy (read port 1, write port 0) or fill (port 0 only).
// Ports: clk, rst_n; start (one-cycle request), mode (0 copy, 1 fill), src_addr, dst_addr,
//        len (0..255, clamped to 128), fill_data; busy, done (one-cycle pulse);
//        ram (RAM bus, master side).
// Copy reads one word per cycle; each word is written the cycle after its read, so din0 is
// steered straight from dout1. Everything else leaving the block comes from a register.
module ram_dma_2p
   import ram_dma_2p_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] fill_data,
   output logic              busy,
   output logic              done,
   ram_dma_2p_if.master      ram
);

   state_e            state_q, state_d;
   mode_e             mode_q, mode_n, mode_in;
   logic [ADDR_W-1:0] src_q, dst_q, src_n, dst_n;
   logic [DATA_W-1:0] fill_q;
   logic [LEN_W-1:0]  len_eff;
   logic              capture, issue, load, step;
   logic [ADDR_W-1:0] off, prev_off;
   logic              last, last_q, last_d;
   logic              re1_q, re1_d, we0_q, we0_d;
   logic [ADDR_W-1:0] addr1_q, addr1_d, addr0_q, addr0_d;
   logic              busy_q, busy_d, done_q, done_d;

   assign mode_in = mode_e'(mode);
   assign len_eff = clamp_len(len);

   dma_addr_gen u_addr_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .step     (step),
      .mode_in  (mode_in),
      .len_in   (len_eff),
      .src_in   (src_addr),
      .dst_in   (dst_addr),
      .off      (off),
      .prev_off (prev_off),
      .last     (last)
   );

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      issue   = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               capture = 1'b1;
               if (len_eff == '0) begin
                  state_d = StDone;
               end else begin
                  load    = 1'b1;
                  issue   = 1'b1;
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (last_q) begin
               state_d = (mode_q == ModeCopy) ? StDrain : StDone;
            end else begin
               issue = 1'b1;
               step  = 1'b1;
            end
         end
         StDrain: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Operands are live on the accepting edge, before the capture registers load.
      mode_n = capture ? mode_in : mode_q;
      src_n  = capture ? src_addr : src_q;
      dst_n  = capture ? dst_addr : dst_q;

      re1_d   = issue && (mode_n == ModeCopy);
      addr1_d = re1_d ? src_n + off : addr1_q;
      if (mode_n == ModeCopy) begin
         // Write trails the read by one cycle at the same offset.
         we0_d   = re1_q;
         addr0_d = re1_q ? dst_q + prev_off : addr0_q;
      end else begin
         we0_d   = issue;
         addr0_d = issue ? dst_n + off : addr0_q;
      end
      last_d = issue && last;
      busy_d = (state_d != StIdle);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         mode_q  <= ModeCopy;
         src_q   <= '0;
         dst_q   <= '0;
         fill_q  <= '0;
         last_q  <= 1'b0;
         re1_q   <= 1'b0;
         we0_q   <= 1'b0;
         addr1_q <= '0;
         addr0_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            mode_q <= mode_in;
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            fill_q <= fill_data;
         end
         last_q  <= last_d;
         re1_q   <= re1_d;
         we0_q   <= we0_d;
         addr1_q <= addr1_d;
         addr0_q <= addr0_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign ram.read_en0  = 1'b0;
   assign ram.write_en1 = 1'b0;
   assign ram.read_en1  = re1_q;
   assign ram.addr1     = addr1_q;
   assign ram.write_en0 = we0_q;
   assign ram.addr0     = addr0_q;
   assign ram.din0      = we0_q ? ((mode_q == ModeFill) ? fill_q : ram.dout1) : '0;

endmodule

// File: doc/ram_dma_2p.md
RAM_DMA_2P -- requirements
Module: ram_dma_2p

Interface
REQ-001 Parameters SHALL be: DATA_W, 16, RAM word width; ADDR_W, 7, RAM address width (128 words).
REQ-002 Ports SHALL be as follows, one clock; reset is asynchronous and active-low:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request pulse
- mode  in  1  0 = copy, 1 = fill
- src_addr  in  ADDR_W  copy source base
- dst_addr  in  ADDR_W  destination base
- len  in  8  word count (0..128)
- fill_data  in  DATA_W  fill pattern
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- read_en0 / write_en0  out  1  RAM port 0 strobes
- addr0  out  ADDR_W  RAM port 0 address
- din0  out  DATA_W  RAM port 0 write data
- read_en1 / write_en1  out  1  RAM port 1 strobes
- addr1  out  ADDR_W  RAM port 1 address
- dout1  in  DATA_W  RAM port 1 read data, valid one cycle after read_en1

Function
REQ-003 Port 1 SHALL be read-only (write_en1 = 0 always); port 0 SHALL be write-only (read_en0 = 0 always).
REQ-004 Operands SHALL be captured on a start pulse seen in IDLE; start while busy is ignored.
REQ-005 States: IDLE, RUN, DRAIN, DONE; IDLE->RUN on an accepted start with len != 0; IDLE->DONE on an accepted start with len == 0; RUN->DRAIN after the last read is issued; DRAIN->DONE after the last write; DONE->IDLE after exactly one cycle.
REQ-006 len values above 128 SHALL be clamped to 128.
REQ-007 Copy: read word k issued at cycle t (read_en1 = 1, addr1 = src + offset_k); the same word is written at t+1 (write_en0 = 1, addr0 = dst + offset_k, din0 = dout1); one word per cycle with no bubbles.
REQ-008 Copy direction: descending (offset_k = len-1-k) when dst is in (src, src+len-1] mod 128; otherwise ascending (offset_k = k), so overlapping copies preserve the source data.
REQ-009 Fill: no reads; writes fill_data to dst+k, one per cycle for len cycles; DRAIN is skipped (RUN->DONE).
REQ-010 All address arithmetic SHALL wrap modulo 128.
REQ-011 busy SHALL be 1 in RUN, DRAIN and DONE; done SHALL be 1 only in DONE.
REQ-012 Copy latency from start to done SHALL be len+2 cycles; fill latency len+1 cycles; len=0 gives done 1 cycle after start with no RAM strobes.
REQ-013 src == dst copies SHALL execute normally (ascending).
REQ-014 All outputs SHALL be registered; RAM strobes SHALL be 0 in IDLE and DONE.

Reset
REQ-015 rst_n low SHALL immediately force IDLE, busy = 0, done = 0, all strobes = 0, addresses and din0 = 0, regardless of any transfer in flight; an aborted transfer does not resume.
REQ-016 After deassertion the block SHALL accept start on the first rising edge.

Structure
REQ-017 A shared package SHALL hold DATA_W, ADDR_W, the RAM depth (128), the state encoding and the mode encodings.
REQ-018 One sub-module, dma_addr_gen, SHALL produce the read/write offsets, direction and last-word flags; the FSM stays in ram_dma_2p.
REQ-019 The block SHALL connect port-for-port to the team's 2-port 16x128 RAM without glue.

Verification
REQ-020 Copy src=0x10, dst=0x40, len=4 from preloaded 0xA000..0xA003 -> words 0x40..0x43 equal 0xA000..0xA003; done 6 cycles after start.
REQ-021 Overlapping copy src=0x20, dst=0x22, len=4 -> descending addresses 0x23..0x20; 0x22..0x25 hold the original 0x20..0x23 contents.
REQ-022 Fill dst=0x7E, len=4, fill_data=0x5A5A -> writes to 0x7E, 0x7F, 0x00, 0x01; done 5 cycles after start.
REQ-023 len=0 -> done 1 cycle after start, no strobes; len=200 -> exactly 128 writes.
REQ-024 rst_n low 3 cycles into len=10 copy -> strobes, busy and done are 0 at once; a subsequent start completes normally.
REQ-025 start pulsed during busy -> ignored; the original transfer's operands and timing are unchanged.
